// File: rtl/priority_encoder_if.sv
// Request/result bundle of the registered priority encoder.
// No handshake: the master presents a request vector every cycle, and the encoded result follows one clock later.
interface priority_encoder_if #(
  parameter int WIDTH = 4
);
  localparam int OUT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] in;
  logic [OUT_W-1:0] out;
  logic             valid;
  logic [WIDTH-1:0] onehot;
  logic             multi;

  modport master (output in, input out, valid, onehot, multi);
  modport slave  (input in, output out, valid, onehot, multi);
endinterface

// File: rtl/priority_encoder.sv
// Registered highest-index-wins priority encoder built from a reduction tree of 2:1 priority cells.
// out, valid, onehot and multi describe the vector that was sampled on the previous rising edge.
module priority_encoder #(
  parameter int WIDTH = 4,
  localparam int OUT_W = $clog2(WIDTH)
) (
  input logic                clk,
  input logic                rst,
  priority_encoder_if.slave  bus
);
  localparam int P = 1 << OUT_W;

  // The tree is stored as a heap. Node 1 is the root, node k has children 2k and 2k+1,
  // and leaf i sits at P+i. Any leaf at or above WIDTH is tied to zero.
  logic             node_v  [1:2*P-1];
  logic [OUT_W-1:0] node_ix [1:2*P-1];

  logic [OUT_W-1:0] out_d, out_q;
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] onehot_d, onehot_q;
  logic             multi_d, multi_q;

  always_comb begin
    for (int k = 1; k < 2 * P; k++) begin
      node_v[k]  = 1'b0;
      node_ix[k] = '0;
    end
    for (int i = 0; i < P; i++) node_ix[P+i] = OUT_W'(i);
    for (int i = 0; i < WIDTH; i++) node_v[P+i] = bus.in[i];
    // Each cell passes the upper half's result when that half holds a request.
    for (int k = P - 1; k >= 1; k--) begin
      node_v[k]  = node_v[2*k] | node_v[2*k+1];
      node_ix[k] = node_v[2*k+1] ? node_ix[2*k+1] : node_ix[2*k];
    end
  end

  always_comb begin
    out_d    = node_ix[1];
    valid_d  = node_v[1];
    onehot_d = node_v[1] ? (WIDTH'(1) << node_ix[1]) : '0;
    multi_d  = |(bus.in & ~onehot_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      valid_q  <= 1'b0;
      onehot_q <= '0;
      multi_q  <= 1'b0;
    end else begin
      out_q    <= out_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.valid  = valid_q;
  assign bus.onehot = onehot_q;
  assign bus.multi  = multi_q;
endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder at WIDTH 4, 8 and 5. All three instances are driven in lockstep, and each
// result is checked against an arithmetic reference model one cycle after its vector is presented.
module tb_priority_encoder;
  localparam int EW = 13;  // {out[2:0], valid, onehot[7:0], multi}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [EW-1:0] exp4_q[$];
  logic [EW-1:0] exp8_q[$];
  logic [EW-1:0] exp5_q[$];
  logic [3:0]    last_in4;

  priority_encoder_if #(.WIDTH(4)) b4 ();
  priority_encoder_if #(.WIDTH(8)) b8 ();
  priority_encoder_if #(.WIDTH(5)) b5 ();

  priority_encoder #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  priority_encoder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  priority_encoder #(.WIDTH(5)) u5 (.clk(clk), .rst(rst), .bus(b5));

  always #5 clk = ~clk;

  // Reference model: the winner is floor(log2(v)), and multi holds when more than one bit is set.
  function automatic logic [EW-1:0] model(input int w, input logic [7:0] v);
    int         idx;
    int         t;
    int         mask;
    logic [7:0] m;
    logic [7:0] oh;
    mask = (1 << w) - 1;
    m = v & mask[7:0];
    if (m == 8'd0) return '0;
    idx = 0;
    t = int'(m);
    while (t > 1) begin
      t = t / 2;
      idx++;
    end
    oh = 8'(1 << idx);
    return {3'(idx), 1'b1, oh, ($countones(m) > 1)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string name, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    check({name, "_out"},    64'(obs[12:10]), 64'(exp[12:10]));
    check({name, "_valid"},  64'(obs[9]),     64'(exp[9]));
    check({name, "_onehot"}, 64'(obs[8:1]),   64'(exp[8:1]));
    check({name, "_multi"},  64'(obs[0]),     64'(exp[0]));
  endtask

  task automatic step(input logic r, input logic [3:0] a4, input logic [7:0] a8, input logic [4:0] a5);
    rst = r;
    b4.in = a4;
    b8.in = a8;
    b5.in = a5;
    last_in4 = a4;
    exp4_q.push_back(r ? '0 : model(4, {4'd0, a4}));
    exp8_q.push_back(r ? '0 : model(8, a8));
    exp5_q.push_back(r ? '0 : model(5, {3'd0, a5}));
    @(posedge clk);
    #1;
    check_fields("w4", {3'(b4.out), b4.valid, 8'(b4.onehot), b4.multi}, exp4_q.pop_front());
    check_fields("w8", {3'(b8.out), b8.valid, 8'(b8.onehot), b8.multi}, exp8_q.pop_front());
    check_fields("w5", {3'(b5.out), b5.valid, 8'(b5.onehot), b5.multi}, exp5_q.pop_front());
  endtask

  initial begin
    logic [3:0] pat4 [4];
    b4.in = '0;
    b8.in = '0;
    b5.in = '0;
    last_in4 = '0;

    // Reset is held with every request active, then released.
    step(1'b1, 4'hF, 8'hFF, 5'h1F);
    step(1'b1, 4'hF, 8'hFF, 5'h1F);
    step(1'b0, 4'hF, 8'hFF, 5'h1F);
    check("rel_out4", 64'(b4.out), 64'd3);
    check("rel_multi4", 64'(b4.multi), 64'd1);

    // Single-bit requests.
    for (int i = 0; i < 5; i++) begin
      logic [3:0] v;
      v = (i == 0) ? 4'd0 : 4'(1 << (i - 1));
      step(1'b0, v, {v, v}, {1'b0, v});
      check("single_onehot", 64'(b4.onehot), 64'(v));
    end

    // Several requests active at once.
    pat4[0] = 4'b1101;
    pat4[1] = 4'b1010;
    pat4[2] = 4'b0110;
    pat4[3] = 4'b0011;
    for (int i = 0; i < 4; i++) step(1'b0, pat4[i], {pat4[i], 4'd0}, {1'b1, pat4[i]});
    step(1'b0, 4'b1101, 8'h00, 5'h00);
    check("p1101_out", 64'(b4.out), 64'd3);
    check("p1101_onehot", 64'(b4.onehot), 64'h8);

    // Back-to-back alternation, with a single reset cycle in the middle.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] v;
      v = i[0] ? 4'b1000 : 4'b0001;
      step(i == 4, v, {v, 4'd0}, {1'b0, v});
    end

    // Every 4-bit input, plus the onehot invariants.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'(i), 8'($urandom), 5'($urandom));
      check("inv_oh_subset", 64'(b4.onehot & ~last_in4), 64'd0);
      check("inv_oh_count", 64'($countones(b4.onehot) > 1), 64'd0);
    end

    // Top bit of each width, then an empty request.
    step(1'b0, 4'd0, 8'h80, 5'b10000);
    check("w8_top_out", 64'(b8.out), 64'd7);
    check("w5_top_out", 64'(b5.out), 64'd4);
    step(1'b0, 4'd0, 8'h00, 5'b00000);
    check("w5_empty_valid", 64'(b5.valid), 64'd0);

    // Random vectors, with an occasional reset.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 24) == 0, 4'($urandom), 8'($urandom), 5'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/priority_encoder.md
# priority_encoder

Registered, parameterizable highest-index-wins priority encoder. Each clock it samples a request vector and reports, one cycle later, the binary index of the highest set bit, a valid flag, the winning bit as one-hot, and a flag for more than one active request. It sits between request sources (interrupt lines, arbiter requests) and the logic that services the top-priority requester.

## Interface

Parameters:
- WIDTH, default 4: number of request inputs; legal range 2..64.
- OUT_W, default $clog2(WIDTH) (2 for WIDTH=4): index width; derived, not overridden.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in, input, WIDTH: request vector; bit i set means requester i is active; bit WIDTH-1 has highest priority.
- out, output, OUT_W: index of highest set bit of the sampled `in`.
- valid, output, 1: 1 when the sampled `in` was nonzero.
- onehot, output, WIDTH: one-hot vector of the winning bit (bit `out` set); all zero when valid=0.
- multi, output, 1: 1 when the sampled `in` had two or more bits set.

## Operation

- Combinational core: scan `in` from bit WIDTH-1 down to bit 0; the first set bit found is the winner.
- Core structure: log2 reduction tree of 2:1 priority cells. Each cell passes the upper half's result when the upper half is nonzero, else the lower half's.
- Index: out = winner index, zero-extended to OUT_W.
- Empty input (in == 0): out = 0, valid = 0, onehot = 0, multi = 0.
  - out = 0 with valid = 0 is the only way to tell empty input from "bit 0 wins". Consumers must qualify `out` with `valid`.
- onehot = (1 << winner) when valid, else 0.
  - Invariant: onehot is zero or has exactly one bit set.
  - Invariant: onehot & ~in_sampled == 0.
- multi = 1 when (in & ~onehot_comb) != 0, where onehot_comb is the combinational one-hot of the same `in`.
- Bits below the winner never affect out, valid or onehot. They affect only multi.
- WIDTH not a power of two: missing upper tree leaves are treated as 0. out never exceeds WIDTH-1.
- No X propagation: with `in` fully 0/1, all outputs are fully 0/1.

## Timing

- All four outputs are registered; latency is exactly 1 clock. Outputs in cycle n+1 reflect `in` sampled at the rising edge ending cycle n.
- No handshake. A new vector is accepted every cycle (throughput 1/cycle).
- `in` must be stable around the rising edge of clk. `in` is not re-registered; the caller synchronizes any asynchronous sources.
- Reset values, while rst=1 at a rising edge: out = 0, valid = 0, onehot = 0, multi = 0.
- Reset overrides sampling. The first encoded result appears on the first edge after rst falls, reflecting `in` at that edge.
- Reset mid-stream: the result in flight is discarded; outputs read 0 on the cycle after the reset edge.
- Holding `in` constant holds all outputs constant (no toggling).
- No internal state beyond the output registers.

## Test plan

- Reset: rst=1 for 2 cycles with in=4'b1111 -> out=00, valid=0, onehot=0000, multi=0 throughout. Release rst -> next cycle out=11, valid=1, onehot=1000, multi=1.
- Single bits: in = 0000, 0001, 0010, 0100, 1000 on consecutive cycles, each checked one cycle later:
  - 0000 -> out=00, valid=0
  - 0001 -> out=00, valid=1
  - 0010 -> out=01, valid=1
  - 0100 -> out=10, valid=1
  - 1000 -> out=11, valid=1
  - multi=0 for all; onehot equals the input.
- Priority with multiple requests:
  - in=1101 -> out=11, onehot=1000, multi=1.
  - in=1010 -> out=11, multi=1.
  - in=0110 -> out=10, onehot=0100, multi=1.
  - in=0011 -> out=01, multi=1.
- Back-to-back and mid-stream reset: alternate in=0001 and in=1000 every cycle -> out alternates 00/11 with 1-cycle lag, valid stays 1. Assert rst for one cycle mid-sequence -> outputs 0 on the following cycle, then resume.
- Exhaustive (WIDTH=4): all 16 input values against a behavioural model, 1-cycle latency. Also check the onehot invariants and out < WIDTH.
- Parameter sweep: WIDTH=8 and WIDTH=5 with random vectors against the behavioural model.
  - WIDTH=8: in=8'h80 -> out=3'd7.
  - WIDTH=5: in=5'b10000 -> out=3'd4; in=5'b00000 -> valid=0.
